// File: rtl/hist_classifier_pkg.sv
// Shared constants, state encoding and helpers for the histogram
// nearest-template classifier.
package hist_classifier_pkg;

    localparam int BIN_W       = 16;
    localparam int ADDR_W      = 9;
    localparam int NUM_BINS    = 512;
    localparam int NUM_CLASSES = 4;
    localparam int CLS_W       = 2;
    localparam int DIST_W      = BIN_W + ADDR_W;
    localparam int CNT_W       = ADDR_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        DRAIN,
        COMPARE,
        DONE
    } state_e;

    // Widen by one bit so the borrow gives the sign, then fold it away.
    function automatic logic [BIN_W-1:0] abs_diff(
        input logic [BIN_W-1:0] a,
        input logic [BIN_W-1:0] b
    );
        logic [BIN_W:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[BIN_W]) begin
            d = -d;
        end
        return d[BIN_W-1:0];
    endfunction

endpackage

// File: rtl/hist_classifier_if.sv
// Bin stream, template load and result bundle of the classifier.
interface hist_classifier_if;
    import hist_classifier_pkg::*;

    logic [BIN_W-1:0]  bin_i;
    logic              bin_valid_i;
    logic              hist_finish_i;
    logic              tpl_we_i;
    logic [CLS_W-1:0]  tpl_class_i;
    logic [ADDR_W-1:0] tpl_addr_i;
    logic [BIN_W-1:0]  tpl_data_i;
    logic [CLS_W-1:0]  class_o;
    logic [DIST_W-1:0] distance_o;
    logic              result_valid_o;
    logic              busy_o;
    logic              len_err_o;

    modport master (
        output bin_i,
        output bin_valid_i,
        output hist_finish_i,
        output tpl_we_i,
        output tpl_class_i,
        output tpl_addr_i,
        output tpl_data_i,
        input  class_o,
        input  distance_o,
        input  result_valid_o,
        input  busy_o,
        input  len_err_o
    );

    modport slave (
        input  bin_i,
        input  bin_valid_i,
        input  hist_finish_i,
        input  tpl_we_i,
        input  tpl_class_i,
        input  tpl_addr_i,
        input  tpl_data_i,
        output class_o,
        output distance_o,
        output result_valid_o,
        output busy_o,
        output len_err_o
    );

endinterface

// File: rtl/hist_template_ram.sv
// One template histogram: single write port, single synchronous read port.
module hist_template_ram
    import hist_classifier_pkg::*;
(
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [BIN_W-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [BIN_W-1:0]  rdata_o
);

    logic [BIN_W-1:0] mem_q [NUM_BINS];
    logic [BIN_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/hist_classifier.sv
// L1 nearest-template classifier over a streamed joint histogram.
module hist_classifier
    import hist_classifier_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    hist_classifier_if.slave bus
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIN_W-1:0]  bin_q, bin_d;
    logic              v1_q, v1_d;
    logic [DIST_W-1:0] acc_q [NUM_CLASSES];
    logic [DIST_W-1:0] acc_d [NUM_CLASSES];
    logic [CLS_W-1:0]  scan_q, scan_d;
    logic [DIST_W-1:0] min_q, min_d;
    logic [CLS_W-1:0]  min_cls_q, min_cls_d;
    logic [CLS_W-1:0]  class_q, class_d;
    logic [DIST_W-1:0] dist_q, dist_d;
    logic              len_err_q, len_err_d;
    logic              accept;
    logic [DIST_W-1:0] cur;
    logic [BIN_W-1:0]  rd_data [NUM_CLASSES];

    // Template loads only land while idle; a class index with no
    // matching memory simply selects nothing.
    for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_ram
        logic we;
        assign we = bus.tpl_we_i && (state_q == IDLE)
                 && (bus.tpl_class_i == CLS_W'(k));

        hist_template_ram u_ram (
            .clk     (clk),
            .we_i    (we),
            .waddr_i (bus.tpl_addr_i),
            .wdata_i (bus.tpl_data_i),
            .raddr_i (cnt_q[ADDR_W-1:0]),
            .rdata_o (rd_data[k])
        );
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bin_d     = bin_q;
        v1_d      = 1'b0;
        acc_d     = acc_q;
        scan_d    = scan_q;
        min_d     = min_q;
        min_cls_d = min_cls_q;
        class_d   = class_q;
        dist_d    = dist_q;
        len_err_d = len_err_q;
        accept    = 1'b0;
        cur       = acc_q[scan_q];

        // Stage 2: template word read last cycle meets the registered bin.
        if (v1_q) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                acc_d[k] = acc_q[k]
                         + DIST_W'(abs_diff(bin_q, rd_data[k]));
            end
        end

        unique case (state_q)
            IDLE: begin
                if (bus.bin_valid_i) begin
                    accept    = 1'b1;
                    len_err_d = 1'b0;
                    state_d   = ACCUM;
                end
            end
            ACCUM: begin
                if (bus.bin_valid_i) begin
                    if (cnt_q != CNT_W'(NUM_BINS)) begin
                        accept = 1'b1;
                    end else begin
                        len_err_d = 1'b1;
                    end
                end
                if (bus.hist_finish_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.bin_valid_i || cnt_q != CNT_W'(NUM_BINS)) begin
                    len_err_d = 1'b1;
                end
                scan_d  = '0;
                state_d = COMPARE;
            end
            COMPARE: begin
                if (bus.bin_valid_i) begin
                    len_err_d = 1'b1;
                end
                if (scan_q == '0 || cur < min_q) begin
                    min_d     = cur;
                    min_cls_d = scan_q;
                end
                if (scan_q == CLS_W'(NUM_CLASSES - 1)) begin
                    class_d = min_cls_d;
                    dist_d  = min_d;
                    state_d = DONE;
                end else begin
                    scan_d = scan_q + CLS_W'(1);
                end
            end
            DONE: begin
                if (bus.bin_valid_i) begin
                    len_err_d = 1'b1;
                end
                cnt_d = '0;
                for (int k = 0; k < NUM_CLASSES; k++) begin
                    acc_d[k] = '0;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Stage 1: present the bin index to every template and hold the bin.
        if (accept) begin
            cnt_d = cnt_q + CNT_W'(1);
            bin_d = bus.bin_i;
            v1_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bin_q     <= '0;
            v1_q      <= 1'b0;
            scan_q    <= '0;
            min_q     <= '0;
            min_cls_q <= '0;
            class_q   <= '0;
            dist_q    <= '0;
            len_err_q <= 1'b0;
            for (int k = 0; k < NUM_CLASSES; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bin_q     <= bin_d;
            v1_q      <= v1_d;
            scan_q    <= scan_d;
            min_q     <= min_d;
            min_cls_q <= min_cls_d;
            class_q   <= class_d;
            dist_q    <= dist_d;
            len_err_q <= len_err_d;
            for (int k = 0; k < NUM_CLASSES; k++) begin
                acc_q[k] <= acc_d[k];
            end
        end
    end

    assign bus.class_o        = class_q;
    assign bus.distance_o     = dist_q;
    assign bus.result_valid_o = (state_q == DONE);
    assign bus.busy_o         = (state_q != IDLE);
    assign bus.len_err_o      = len_err_q;

endmodule

// File: tb/tb_hist_classifier.sv
// Directed and randomized frames for hist_classifier, checked against
// a plain-arithmetic nearest-template model.
module tb_hist_classifier;
    import hist_classifier_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    hist_classifier_if bus ();

    hist_classifier dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int tpl_m [NUM_CLASSES][NUM_BINS];
    int sb    [600];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic load_tpls();
        for (int c = 0; c < NUM_CLASSES; c++) begin
            for (int a = 0; a < NUM_BINS; a++) begin
                @(posedge clk); #1;
                bus.tpl_we_i    = 1'b1;
                bus.tpl_class_i = CLS_W'(c);
                bus.tpl_addr_i  = ADDR_W'(a);
                bus.tpl_data_i  = BIN_W'(tpl_m[c][a]);
            end
        end
        @(posedge clk); #1;
        bus.tpl_we_i = 1'b0;
    endtask

    // Nearest template by L1 over the first NUM_BINS streamed bins.
    function automatic void model(input int n, output int ecls,
                                  output int edist);
        int d;
        int m;
        m     = (n > NUM_BINS) ? NUM_BINS : n;
        ecls  = 0;
        edist = 0;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            d = 0;
            for (int i = 0; i < m; i++) begin
                if (sb[i] > tpl_m[c][i]) d += sb[i] - tpl_m[c][i];
                else                     d += tpl_m[c][i] - sb[i];
            end
            if (c == 0 || d < edist) begin
                edist = d;
                ecls  = c;
            end
        end
    endfunction

    task automatic run_frame(string tag, int n, bit gaps, bit fin_last,
                             bit do_wr);
        int ecls;
        int edist;
        int lat;
        model(n, ecls, edist);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                chk({tag, "_lenerr_start"}, bus.len_err_o, 0);
                chk({tag, "_busy"}, bus.busy_o, 1);
            end
            if (i == NUM_BINS + 1) begin
                chk({tag, "_lenerr_over"}, bus.len_err_o, 1);
            end
            bus.tpl_we_i = do_wr && (i == 10);
            if (do_wr && i == 10) begin
                bus.tpl_class_i = CLS_W'(ecls);
                bus.tpl_addr_i  = ADDR_W'(NUM_BINS - 1);
                bus.tpl_data_i  = BIN_W'(tpl_m[ecls][NUM_BINS-1] ^ 32'h8000);
            end
            bus.bin_valid_i   = 1'b1;
            bus.bin_i         = BIN_W'(sb[i]);
            bus.hist_finish_i = fin_last && (i == n - 1);
            if (gaps) begin
                @(posedge clk); #1;
                bus.bin_valid_i = 1'b0;
                bus.tpl_we_i    = 1'b0;
            end
        end
        if (!fin_last) begin
            @(posedge clk); #1;
            bus.bin_valid_i   = 1'b0;
            bus.tpl_we_i      = 1'b0;
            bus.hist_finish_i = 1'b1;
        end
        @(posedge clk); #1;
        bus.bin_valid_i   = 1'b0;
        bus.tpl_we_i      = 1'b0;
        bus.hist_finish_i = 1'b0;
        lat = 1;
        while (!bus.result_valid_o && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, NUM_CLASSES + 2);
        chk({tag, "_valid"}, bus.result_valid_o, 1);
        chk({tag, "_class"}, bus.class_o, ecls);
        chk({tag, "_dist"}, bus.distance_o, edist);
        chk({tag, "_lenerr"}, bus.len_err_o, (n != NUM_BINS) ? 1 : 0);
        @(posedge clk); #1;
        chk({tag, "_pulse"}, bus.result_valid_o, 0);
        chk({tag, "_idle"}, bus.busy_o, 0);
    endtask

    initial begin
        int pulses;
        bus.bin_i         = '0;
        bus.bin_valid_i   = 1'b0;
        bus.hist_finish_i = 1'b0;
        bus.tpl_we_i      = 1'b0;
        bus.tpl_class_i   = '0;
        bus.tpl_addr_i    = '0;
        bus.tpl_data_i    = '0;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_class", bus.class_o, 0);
        chk("rst_dist", bus.distance_o, 0);
        chk("rst_valid", bus.result_valid_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_lenerr", bus.len_err_o, 0);

        // Class 2 matches the stream exactly.
        for (int c = 0; c < NUM_CLASSES; c++)
            for (int a = 0; a < NUM_BINS; a++) tpl_m[c][a] = 10 * c;
        load_tpls();
        for (int i = 0; i < 600; i++) sb[i] = 20;
        run_frame("match", 512, 1'b0, 1'b0, 1'b0);

        // Gapped stream, small nonzero distance.
        for (int c = 0; c < NUM_CLASSES; c++)
            for (int a = 0; a < NUM_BINS; a++) tpl_m[c][a] = (c == 1) ? 5 : 0;
        load_tpls();
        for (int i = 0; i < 600; i++) sb[i] = 3;
        run_frame("gaps", 512, 1'b1, 1'b0, 1'b0);

        // Classes 0 and 3 tie at the minimum.
        for (int a = 0; a < NUM_BINS; a++) begin
            tpl_m[0][a] = 11;
            tpl_m[1][a] = 13;
            tpl_m[2][a] = 12;
            tpl_m[3][a] = 9;
        end
        load_tpls();
        for (int i = 0; i < 600; i++) sb[i] = 10;
        run_frame("tie", 512, 1'b0, 1'b0, 1'b0);

        // Random templates and streams, including length errors.
        for (int c = 0; c < NUM_CLASSES; c++)
            for (int a = 0; a < NUM_BINS; a++)
                tpl_m[c][a] = int'($urandom_range(0, 65535));
        load_tpls();
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 600; i++)
                sb[i] = int'($urandom_range(0, 65535));
            run_frame("rnd", 512, f[0], 1'b0, 1'b0);
        end
        for (int i = 0; i < 600; i++) sb[i] = int'($urandom_range(0, 65535));
        run_frame("lenA", 500, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 600; i++) sb[i] = int'($urandom_range(0, 65535));
        run_frame("lenB", 514, 1'b0, 1'b0, 1'b0);

        // Abort at bin 200, then rerun on the same templates.
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            bus.bin_valid_i = 1'b1;
            bus.bin_i       = BIN_W'(sb[i]);
        end
        @(posedge clk); #1;
        bus.bin_valid_i = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", bus.busy_o, 0);
        chk("abort_valid", bus.result_valid_o, 0);
        chk("abort_dist", bus.distance_o, 0);
        chk("abort_class", bus.class_o, 0);
        chk("abort_lenerr", bus.len_err_o, 0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.result_valid_o) pulses++;
        end
        chk("abort_nopulse", pulses, 0);
        run_frame("rerun", 512, 1'b0, 1'b0, 1'b0);

        // Template write attempted mid-frame must be dropped.
        for (int c = 0; c < NUM_CLASSES; c++)
            for (int a = 0; a < NUM_BINS; a++) tpl_m[c][a] = 10 * c;
        load_tpls();
        for (int i = 0; i < 600; i++) sb[i] = 20;
        run_frame("wrblk", 512, 1'b0, 1'b0, 1'b1);

        // Full-scale distance, last bin coincident with finish.
        for (int c = 0; c < NUM_CLASSES; c++)
            for (int a = 0; a < NUM_BINS; a++) tpl_m[c][a] = 0;
        load_tpls();
        for (int i = 0; i < 600; i++) sb[i] = 65535;
        run_frame("max", 512, 1'b0, 1'b1, 1'b0);
        chk("max_const", bus.distance_o, 33553920);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hist_classifier.md
Name: hist_classifier

Overview:
- Downstream consumer of the joint CI/NI/RD histogram stage.
- Takes the histogram read-out stream: one 16-bit bin per valid cycle, bins in address order {ci, ni, rd}.
- Computes the L1 (sum of absolute differences) distance to NUM_CLASSES stored template histograms, all in parallel.
- At frame end, reports the nearest class and its distance.

Parameters:
- BIN_W, 16, bin count width.
- ADDR_W, 9, bin index width (1 ci + 4 ni + 4 rd).
- NUM_BINS, 512, bins per histogram.
- NUM_CLASSES, 4, template count.
- CLS_W, 2, class index width.
- DIST_W, 25, accumulator width; equals BIN_W + ADDR_W, so it cannot overflow.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- bin_i  in  BIN_W  histogram bin value.
- bin_valid_i  in  1  bin_i valid (driven by histogram done_o).
- hist_finish_i  in  1  one-cycle pulse: histogram stream complete.
- tpl_we_i  in  1  template write enable.
- tpl_class_i  in  CLS_W  template class to write.
- tpl_addr_i  in  ADDR_W  template bin address.
- tpl_data_i  in  BIN_W  template bin value.
- class_o  out  CLS_W  nearest class.
- distance_o  out  DIST_W  L1 distance of the nearest class.
- result_valid_o  out  1  one-cycle result strobe.
- busy_o  out  1  high in any state other than IDLE.
- len_err_o  out  1  bin count at finish was not NUM_BINS; sticky until next frame start.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - Bin counter and all NUM_CLASSES accumulators cleared.
  - Template memories are not reset; contents persist.
- Template memories:
  - NUM_CLASSES x NUM_BINS x BIN_W, synchronous read, one read port per class.
  - Writes accepted only in IDLE; silently ignored otherwise.
  - Class indices >= NUM_CLASSES are ignored.
- States:
  - IDLE: first bin_valid_i moves to ACCUM; that bin is processed. Entering ACCUM clears len_err_o.
  - ACCUM:
    - Each bin_valid_i: template address = bin counter; counter increments; bin_i is registered.
    - Next cycle: each class adds |bin_reg - tpl_rd[k]| to acc[k].
    - Stage 1 (address/register) and stage 2 (accumulate) are pipelined; back-to-back valids are supported at one bin per cycle.
    - Bins arriving after counter = NUM_BINS are dropped; len_err_o is set.
    - hist_finish_i moves to DRAIN. If bin_valid_i and hist_finish_i are in the same cycle, that bin is counted first.
  - DRAIN:
    - One cycle, so the final pipelined add completes.
    - If counter != NUM_BINS at finish, len_err_o is set.
    - Moves to COMPARE.
  - COMPARE:
    - Scans k = 0..NUM_CLASSES-1, one per cycle; keeps the minimum.
    - Tie: strict less-than, so the lowest index wins.
    - After the last class, moves to DONE.
  - DONE:
    - class_o and distance_o are updated; result_valid_o pulses 1 cycle.
    - Accumulators and counter are cleared; returns to IDLE.
    - class_o and distance_o hold until the next DONE.
- Finish latency: hist_finish_i to result_valid_o = NUM_CLASSES + 2 cycles.
- Inputs outside their states:
  - bin_valid_i during DRAIN, COMPARE or DONE is ignored; len_err_o is set.
  - hist_finish_i in IDLE is ignored.
- Subtraction: unsigned operands are widened to BIN_W+1, then absolute value is taken. Accumulation is unsigned and cannot overflow.
- rst mid-operation:
  - Abort; return to IDLE with reset values.
  - No result_valid_o pulse.
  - Templates intact.

Decomposition:
- Package hist_classifier_pkg: BIN_W, ADDR_W, NUM_BINS, NUM_CLASSES, DIST_W constants and the state enum (IDLE, ACCUM, DRAIN, COMPARE, DONE).
- Sub-module hist_template_ram: one single-write, single-synchronous-read BIN_W x NUM_BINS memory, instantiated NUM_CLASSES times via generate.
- Control FSM, accumulators and the min scan stay in the top module.

Test Plan:
- Class 2 template equal to the stream, others differ:
  - Stimulus: load class k with all bins = 10·k; stream 512 bins of 20, then finish.
  - Response: class_o=2, distance_o=0, result_valid_o exactly NUM_CLASSES+2 cycles after finish, len_err_o=0.
- Nonzero distance:
  - Stimulus: templates all 0 except class 1 = 5; stream 512 bins of 3 with gaps (valid every other cycle).
  - Response: class_o=1, distance_o=1024.
- Tie:
  - Stimulus: classes 0 and 3 identical, both at minimum distance 512.
  - Response: class_o=0.
- Length errors:
  - Stimulus A: finish after 500 bins. Response: result produced, len_err_o=1.
  - Stimulus B: next frame of 514 bins. Response: len_err_o cleared at start, then set again; the 2 extra bins do not change distance.
- Maximum distance and simultaneous valid/finish:
  - Stimulus: template all 0, stream all 65535; last bin_valid_i in the same cycle as hist_finish_i.
  - Response: distance_o=33553920, no wrap.
- Reset and write blocking:
  - Stimulus: assert rst at bin 200.
  - Response: no result_valid_o; busy_o=0 next cycle; a rerun matches the golden result without reloading templates.
  - Stimulus: template write during ACCUM.
  - Response: write ignored.
